// File: rtl/mem_ctrl_sequencer.sv
// mem_ctrl_sequencer
//   Hardwired control-step sequencer for the memory-format instructions
//   (ld, ldi, st). On i_start it fetches the instruction, decodes the IR
//   opcode in T3 and issues the per-step DataPath control strobes. Memory
//   steps hold Read/Write for MEM_WAIT extra cycles.
//
//   Optional feature macro: MEM_CTRL_SEQ_STORE_EN
//     defined     -> st path (T6 Gra/Rout/MDRin, T7 Write) is built
//     not defined -> OP_ST decodes as illegal, o_Write/o_Rout tied 0
//
// Ports
//   i_clock            system clock, rising edge
//   i_clear            asynchronous active-high reset
//   i_start            begin one instruction (sampled only in IDLE)
//   i_ir_op[4:0]       IR[31:27], valid from the cycle after IRin
//   o_busy             high from T0 through the last step
//   o_done             one-cycle pulse after the last step
//   o_illegal          one-cycle pulse in T3 for an unsupported opcode
//   o_alu_op[4:0]      ALU_ADD in T4, otherwise 0
//   o_PCout .. o_BAout DataPath control strobes
module mem_ctrl_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  OP_LD    = 5'b00000,
  parameter logic [4:0]  OP_LDI   = 5'b00001,
  parameter logic [4:0]  OP_ST    = 5'b00010,
  parameter logic [4:0]  ALU_ADD  = 5'b00011
) (
  input  logic       i_clock,
  input  logic       i_clear,
  input  logic       i_start,
  input  logic [4:0] i_ir_op,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_illegal,
  output logic [4:0] o_alu_op,
  output logic       o_PCout,
  output logic       o_PCin,
  output logic       o_IncPC,
  output logic       o_MARin,
  output logic       o_MDRin,
  output logic       o_MDRout,
  output logic       o_IRin,
  output logic       o_Yin,
  output logic       o_Zin,
  output logic       o_Zlowout,
  output logic       o_Cout,
  output logic       o_Read,
  output logic       o_Write,
  output logic       o_Gra,
  output logic       o_Grb,
  output logic       o_Rin,
  output logic       o_Rout,
  output logic       o_BAout
);

  localparam int unsigned CNT_W = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

`ifdef MEM_CTRL_SEQ_STORE_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  // Registered control-word bit positions. Grb/BAout/Yin/illegal are all
  // derived from the T3 flag because they depend on the opcode seen in T3.
  localparam int unsigned C_PCOUT  = 0;
  localparam int unsigned C_PCIN   = 1;
  localparam int unsigned C_INCPC  = 2;
  localparam int unsigned C_MARIN  = 3;
  localparam int unsigned C_MDRIN  = 4;
  localparam int unsigned C_MDROUT = 5;
  localparam int unsigned C_IRIN   = 6;
  localparam int unsigned C_ZIN    = 7;
  localparam int unsigned C_ZLOW   = 8;
  localparam int unsigned C_COUT   = 9;
  localparam int unsigned C_READ   = 10;
  localparam int unsigned C_GRA    = 11;
  localparam int unsigned C_RIN    = 12;
  localparam int unsigned C_T3     = 13;
  localparam int unsigned C_BUSY   = 14;
  localparam int unsigned C_DONE   = 15;
  localparam int unsigned CTRL_W   = 16;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_DONE = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    K_LD  = 2'd0,
    K_LDI = 2'd1,
    K_ST  = 2'd2
  } op_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  op_e                r_op;
  op_e                w_op_nxt;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [CTRL_W-1:0]  w_ctrl_nxt;
  logic [4:0]         r_alu_op;
  logic [4:0]         w_alu_op_nxt;
  logic               w_last_nxt;
`ifdef MEM_CTRL_SEQ_STORE_EN
  logic               r_write;
  logic               r_rout;
  logic               w_write_nxt;
  logic               w_rout_nxt;
`endif

  // Opcode decode of the live IR field, only meaningful during T3.
  logic w_is_ld;
  logic w_is_ldi;
  logic w_is_st;
  logic w_legal;

  assign w_is_ld  = (i_ir_op == OP_LD);
  assign w_is_ldi = (i_ir_op == OP_LDI);
  assign w_is_st  = (i_ir_op == OP_ST);
  assign w_legal  = w_is_ld | w_is_ldi | (w_is_st & ST_EN);

  // Next state / counter, then control word decoded from the next state so
  // every strobe comes straight out of a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_op_nxt     = r_op;
    w_ctrl_nxt   = '0;
    w_alu_op_nxt = '0;
    w_last_nxt   = 1'b0;
`ifdef MEM_CTRL_SEQ_STORE_EN
    w_write_nxt  = 1'b0;
    w_rout_nxt   = 1'b0;
`endif

    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_T0;
      S_T0:   w_state_nxt = S_T1;
      S_T1: begin
        if (r_cnt == CNT_LAST) w_state_nxt = S_T2;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_T2:   w_state_nxt = S_T3;
      S_T3: begin
        if (w_legal) begin
          w_state_nxt = S_T4;
          if (w_is_ldi)     w_op_nxt = K_LDI;
`ifdef MEM_CTRL_SEQ_STORE_EN
          else if (w_is_st) w_op_nxt = K_ST;
`endif
          else              w_op_nxt = K_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_T4:   w_state_nxt = S_T5;
      S_T5:   w_state_nxt = (r_op == K_LDI) ? S_DONE : S_T6;
      S_T6: begin
`ifdef MEM_CTRL_SEQ_STORE_EN
        if (r_op == K_ST)             w_state_nxt = S_T7;
        else if (r_cnt == CNT_LAST)   w_state_nxt = S_T7;
        else                          w_cnt_nxt   = r_cnt + CNT_W'(1);
`else
        if (r_cnt == CNT_LAST) w_state_nxt = S_T7;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
`endif
      end
      S_T7: begin
`ifdef MEM_CTRL_SEQ_STORE_EN
        if (r_op == K_ST) begin
          if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
          else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = S_DONE;
        end
`else
        w_state_nxt = S_DONE;
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_last_nxt = (w_cnt_nxt == CNT_LAST);

    case (w_state_nxt)
      S_T0: begin
        w_ctrl_nxt[C_BUSY]  = 1'b1;
        w_ctrl_nxt[C_PCOUT] = 1'b1;
        w_ctrl_nxt[C_MARIN] = 1'b1;
        w_ctrl_nxt[C_INCPC] = 1'b1;
        w_ctrl_nxt[C_ZIN]   = 1'b1;
      end
      S_T1: begin
        w_ctrl_nxt[C_BUSY]  = 1'b1;
        w_ctrl_nxt[C_READ]  = 1'b1;
        w_ctrl_nxt[C_ZLOW]  = w_last_nxt;
        w_ctrl_nxt[C_PCIN]  = w_last_nxt;
        w_ctrl_nxt[C_MDRIN] = w_last_nxt;
      end
      S_T2: begin
        w_ctrl_nxt[C_BUSY]   = 1'b1;
        w_ctrl_nxt[C_MDROUT] = 1'b1;
        w_ctrl_nxt[C_IRIN]   = 1'b1;
      end
      S_T3: begin
        w_ctrl_nxt[C_BUSY] = 1'b1;
        w_ctrl_nxt[C_T3]   = 1'b1;
      end
      S_T4: begin
        w_ctrl_nxt[C_BUSY] = 1'b1;
        w_ctrl_nxt[C_COUT] = 1'b1;
        w_ctrl_nxt[C_ZIN]  = 1'b1;
        w_alu_op_nxt       = ALU_ADD;
      end
      S_T5: begin
        w_ctrl_nxt[C_BUSY] = 1'b1;
        w_ctrl_nxt[C_ZLOW] = 1'b1;
        if (w_op_nxt == K_LDI) begin
          w_ctrl_nxt[C_GRA] = 1'b1;
          w_ctrl_nxt[C_RIN] = 1'b1;
        end else begin
          w_ctrl_nxt[C_MARIN] = 1'b1;
        end
      end
      S_T6: begin
        w_ctrl_nxt[C_BUSY] = 1'b1;
`ifdef MEM_CTRL_SEQ_STORE_EN
        if (w_op_nxt == K_ST) begin
          // Read stays low so MDR captures the register value off the bus.
          w_ctrl_nxt[C_GRA]   = 1'b1;
          w_ctrl_nxt[C_MDRIN] = 1'b1;
          w_rout_nxt          = 1'b1;
        end else begin
          w_ctrl_nxt[C_READ]  = 1'b1;
          w_ctrl_nxt[C_MDRIN] = w_last_nxt;
        end
`else
        w_ctrl_nxt[C_READ]  = 1'b1;
        w_ctrl_nxt[C_MDRIN] = w_last_nxt;
`endif
      end
      S_T7: begin
        w_ctrl_nxt[C_BUSY] = 1'b1;
`ifdef MEM_CTRL_SEQ_STORE_EN
        if (w_op_nxt == K_ST) begin
          w_write_nxt = 1'b1;
        end else begin
          w_ctrl_nxt[C_MDROUT] = 1'b1;
          w_ctrl_nxt[C_GRA]    = 1'b1;
          w_ctrl_nxt[C_RIN]    = 1'b1;
        end
`else
        w_ctrl_nxt[C_MDROUT] = 1'b1;
        w_ctrl_nxt[C_GRA]    = 1'b1;
        w_ctrl_nxt[C_RIN]    = 1'b1;
`endif
      end
      S_DONE:  w_ctrl_nxt[C_DONE] = 1'b1;
      default: w_ctrl_nxt = '0;
    endcase
  end

  // State, wait counter, latched opcode class and registered control word.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= K_LD;
      r_ctrl   <= '0;
      r_alu_op <= '0;
`ifdef MEM_CTRL_SEQ_STORE_EN
      r_write  <= 1'b0;
      r_rout   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_alu_op <= w_alu_op_nxt;
`ifdef MEM_CTRL_SEQ_STORE_EN
      r_write  <= w_write_nxt;
      r_rout   <= w_rout_nxt;
`endif
    end
  end

  assign o_PCout   = r_ctrl[C_PCOUT];
  assign o_PCin    = r_ctrl[C_PCIN];
  assign o_IncPC   = r_ctrl[C_INCPC];
  assign o_MARin   = r_ctrl[C_MARIN];
  assign o_MDRin   = r_ctrl[C_MDRIN];
  assign o_MDRout  = r_ctrl[C_MDROUT];
  assign o_IRin    = r_ctrl[C_IRIN];
  assign o_Zin     = r_ctrl[C_ZIN];
  assign o_Zlowout = r_ctrl[C_ZLOW];
  assign o_Cout    = r_ctrl[C_COUT];
  assign o_Read    = r_ctrl[C_READ];
  assign o_Gra     = r_ctrl[C_GRA];
  assign o_Rin     = r_ctrl[C_RIN];
  assign o_busy    = r_ctrl[C_BUSY];
  assign o_done    = r_ctrl[C_DONE];
  assign o_alu_op  = r_alu_op;

  // T3 strobes are suppressed for an unsupported opcode; IR is stable
  // throughout T3, so gating with the live decode does not glitch.
  assign o_Grb     = r_ctrl[C_T3] & w_legal;
  assign o_BAout   = r_ctrl[C_T3] & w_legal;
  assign o_Yin     = r_ctrl[C_T3] & w_legal;
  assign o_illegal = r_ctrl[C_T3] & ~w_legal;

`ifdef MEM_CTRL_SEQ_STORE_EN
  assign o_Write = r_write;
  assign o_Rout  = r_rout;
`else
  assign o_Write = 1'b0;
  assign o_Rout  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl_sequencer.sv
// Testbench for mem_ctrl_sequencer: three instances (MEM_WAIT = 0, 1, 3)
// share stimulus; each is compared every cycle against an expected
// control-word trace built from the step rules.
module tb_mem_ctrl_sequencer;

`ifdef MEM_CTRL_SEQ_STORE_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  // Observed word layout: [17:0] strobes, 18 busy, 19 done, 20 illegal, [25:21] alu_op
  localparam logic [25:0] M_PCOUT  = 26'd1 << 0;
  localparam logic [25:0] M_PCIN   = 26'd1 << 1;
  localparam logic [25:0] M_INCPC  = 26'd1 << 2;
  localparam logic [25:0] M_MARIN  = 26'd1 << 3;
  localparam logic [25:0] M_MDRIN  = 26'd1 << 4;
  localparam logic [25:0] M_MDROUT = 26'd1 << 5;
  localparam logic [25:0] M_IRIN   = 26'd1 << 6;
  localparam logic [25:0] M_YIN    = 26'd1 << 7;
  localparam logic [25:0] M_ZIN    = 26'd1 << 8;
  localparam logic [25:0] M_ZLOW   = 26'd1 << 9;
  localparam logic [25:0] M_COUT   = 26'd1 << 10;
  localparam logic [25:0] M_READ   = 26'd1 << 11;
  localparam logic [25:0] M_WRITE  = 26'd1 << 12;
  localparam logic [25:0] M_GRA    = 26'd1 << 13;
  localparam logic [25:0] M_GRB    = 26'd1 << 14;
  localparam logic [25:0] M_RIN    = 26'd1 << 15;
  localparam logic [25:0] M_ROUT   = 26'd1 << 16;
  localparam logic [25:0] M_BAOUT  = 26'd1 << 17;
  localparam logic [25:0] M_BUSY   = 26'd1 << 18;
  localparam logic [25:0] M_DONE   = 26'd1 << 19;
  localparam logic [25:0] M_ILL    = 26'd1 << 20;
  localparam logic [25:0] M_ALUADD = 26'(5'b00011) << 21;

  logic       clk;
  logic       clear;
  logic       start;
  logic [4:0] ir_op;
  logic [25:0] obs [3];

  int checks;
  int failures;
  int fail_prints;

  logic [25:0] tr [3][32];
  int tlen [3];
  int tpos [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic busy, done, ill;
    logic [4:0] alu;
    logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, yin, zin, zlow;
    logic cout, rd, wr, gra, grb, rin, rout, baout;

    mem_ctrl_sequencer #(.MEM_WAIT((g == 0) ? 0 : (g == 1) ? 1 : 3)) u_dut (
      .i_clock   (clk),
      .i_clear   (clear),
      .i_start   (start),
      .i_ir_op   (ir_op),
      .o_busy    (busy),
      .o_done    (done),
      .o_illegal (ill),
      .o_alu_op  (alu),
      .o_PCout   (pcout),
      .o_PCin    (pcin),
      .o_IncPC   (incpc),
      .o_MARin   (marin),
      .o_MDRin   (mdrin),
      .o_MDRout  (mdrout),
      .o_IRin    (irin),
      .o_Yin     (yin),
      .o_Zin     (zin),
      .o_Zlowout (zlow),
      .o_Cout    (cout),
      .o_Read    (rd),
      .o_Write   (wr),
      .o_Gra     (gra),
      .o_Grb     (grb),
      .o_Rin     (rin),
      .o_Rout    (rout),
      .o_BAout   (baout)
    );

    assign obs[g] = {alu, ill, done, busy, baout, rout, rin, grb, gra, wr, rd, cout,
                     zlow, zin, yin, irin, mdrout, mdrin, marin, incpc, pcin, pcout};
  end

  function automatic int w_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
    end
  endtask

  task automatic push(input int g, input logic [25:0] wd);
    tr[g][tlen[g]] = wd;
    tlen[g]++;
  endtask

  // Expected per-cycle control words from T0 through DONE (or the illegal T3).
  task automatic build(input int g, input logic [4:0] op);
    int w;
    bit ld, ldi, st;
    w    = w_of(g);
    ld   = (op == 5'b00000);
    ldi  = (op == 5'b00001);
    st   = (op == 5'b00010) && ST_EN;
    tlen[g] = 0;
    tpos[g] = 0;
    push(g, M_BUSY | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    for (int i = 0; i <= w; i++)
      push(g, M_BUSY | M_READ | ((i == w) ? (M_ZLOW | M_PCIN | M_MDRIN) : 26'd0));
    push(g, M_BUSY | M_MDROUT | M_IRIN);
    if (!(ld || ldi || st)) begin
      push(g, M_BUSY | M_ILL);
      return;
    end
    push(g, M_BUSY | M_GRB | M_BAOUT | M_YIN);
    push(g, M_BUSY | M_COUT | M_ZIN | M_ALUADD);
    if (ldi) begin
      push(g, M_BUSY | M_ZLOW | M_GRA | M_RIN);
    end else begin
      push(g, M_BUSY | M_ZLOW | M_MARIN);
      if (ld) begin
        for (int i = 0; i <= w; i++)
          push(g, M_BUSY | M_READ | ((i == w) ? M_MDRIN : 26'd0));
        push(g, M_BUSY | M_MDROUT | M_GRA | M_RIN);
      end else begin
        push(g, M_BUSY | M_GRA | M_ROUT | M_MDRIN);
        for (int i = 0; i <= w; i++)
          push(g, M_BUSY | M_WRITE);
      end
    end
    push(g, M_DONE);
  endtask

  function automatic bit all_idle();
    for (int g = 0; g < 3; g++)
      if (tpos[g] < tlen[g]) return 1'b0;
    return 1'b1;
  endfunction

  // Per-cycle comparison and model advance.
  initial begin
    logic [25:0] exp;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        exp = (clear || tpos[g] >= tlen[g]) ? 26'd0 : tr[g][tpos[g]];
        chk($sformatf("cyc_g%0d", g), 32'(obs[g]), 32'(exp));
        if (clear) begin
          tlen[g] = 0;
          tpos[g] = 0;
        end else if (tpos[g] < tlen[g]) begin
          tpos[g]++;
        end else if (start) begin
          build(g, ir_op);
        end
      end
    end
  end

  task automatic run_dir(input string nm, input logic [4:0] op, input int e0, input int e1,
                         input int e2, input int ebusy, input int eill, input bit pulse);
    int dn [3];
    int bc [3];
    int e  [3];
    int ic;
    e[0] = e0; e[1] = e1; e[2] = e2;
    ic = 0;
    for (int g = 0; g < 3; g++) begin
      dn[g] = 0;
      bc[g] = 0;
    end
    ir_op = op;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (obs[g][19] && dn[g] == 0) dn[g] = n;
        if (obs[g][18]) bc[g]++;
        if (obs[g][20]) ic++;
      end
      if (pulse && n == 2) begin @(posedge clk); #1 start = 1'b1; end
      if (pulse && n == 3) begin @(posedge clk); #1 start = 1'b0; end
    end
    for (int g = 0; g < 3; g++)
      chk($sformatf("%s_done_cycle_g%0d", nm, g), 32'(dn[g]), 32'(e[g]));
    chk($sformatf("%s_busy_cycles_g0", nm), 32'(bc[0]), 32'(ebusy));
    chk($sformatf("%s_illegal_pulses", nm), 32'(ic), 32'(eill));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] r;
    checks = 0; failures = 0; fail_prints = 0;
    clear = 1'b1; start = 1'b0; ir_op = 5'd0;
    for (int g = 0; g < 3; g++) begin tlen[g] = 0; tpos[g] = 0; end

    // Hand-computed anchors for the trace model.
    build(0, 5'b00000); chk("pin_ld_w0_len", 32'(tlen[0]), 32'd9);
    build(2, 5'b00000); chk("pin_ld_w3_len", 32'(tlen[2]), 32'd15);
    chk("pin_ld_w3_t1_last", 32'(tr[2][4]), 32'h0040A12);
    chk("pin_ld_w3_t4", 32'(tr[2][7]), 32'h0640500);
    build(0, 5'b00001); chk("pin_ldi_w0_len", 32'(tlen[0]), 32'd7);
    build(1, 5'b00010); chk("pin_st_w1_len", 32'(tlen[1]), ST_EN ? 32'd11 : 32'd5);
    for (int g = 0; g < 3; g++) begin tlen[g] = 0; tpos[g] = 0; end

    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(posedge clk); #1;

    run_dir("ld",  5'b00000, 9, 11, 15, 8, 0, 1'b1);
    run_dir("ldi", 5'b00001, 7, 8, 10, 6, 0, 1'b0);
    run_dir("st",  5'b00010, ST_EN ? 9 : 0, ST_EN ? 11 : 0, ST_EN ? 15 : 0,
            ST_EN ? 8 : 4, ST_EN ? 0 : 3, 1'b0);
    run_dir("bad", 5'b11111, 0, 0, 0, 4, 3, 1'b0);

    // Abort an ld in T4 (MEM_WAIT=0 instance) with clear.
    ir_op = 5'b00000;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_before_clear_g0", 32'(obs[0]), 32'h0640500);
    #1 clear = 1'b1;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("clear_all_zero_g%0d", g), 32'(obs[g]), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_dir("ld_after_clear", 5'b00000, 9, 11, 15, 8, 0, 1'b0);

    // Randomised traffic, including starts while busy and occasional clears.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      clear = (!clear && $urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      if (all_idle()) begin
        r = 3'($urandom_range(0, 3));
        ir_op = (r == 3'd3) ? 5'($urandom) : 5'(r);
      end
    end

    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b0;
    repeat (40) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_sequencer.md
# mem_ctrl_sequencer

Hardwired control-step sequencer for the memory-format instructions (ld, ldi, st) of the phase-2 datapath. Replaces hand-driven T0–T7 control pulses: on `start` it runs instruction fetch, decodes the IR opcode and issues the per-step control word to DataPath. Memory latency is parametrised, so `Read`/`Write` are held for a configurable number of wait cycles. Sits between the top-level CPU control and the DataPath control inputs.

## Interface
- `MEM_WAIT`, 0: extra cycles `Read`/`Write` are held before the memory step completes (0–15).
- `OP_LD`, 5'b00000: ld opcode.
- `OP_LDI`, 5'b00001: ldi opcode.
- `OP_ST`, 5'b00010: st opcode.
- `ALU_ADD`, 5'b00011: ALU opcode driven during effective-address add.

- `clock`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin one instruction; sampled only in IDLE.
- `ir_op`  in  5  IR[31:27]; valid from the cycle after IRin.
- `busy`  out  1  high from T0 through the last step.
- `done`  out  1  one-cycle pulse after the last step.
- `illegal`  out  1  one-cycle pulse, unsupported opcode.
- `alu_op`  out  5  ALU opcode; `ALU_ADD` in T4, else 0.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Cout`, `Read`, `Write`, `Gra`, `Grb`, `Rin`, `Rout`, `BAout`  out  1 each  DataPath control strobes.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE. All outputs are Moore decodes of state plus wait counter. Exactly the listed strobes are high in each state; all others are 0.
- IDLE: all outputs 0. If `start` is high, go to T0.
- T0: `PCout MARin IncPC Zin`.
- T1 (memory step): `Read` is high for MEM_WAIT+1 cycles. `Zlowout PCin MDRin` are high only in the final cycle.
- T2: `MDRout IRin`.
- T3: `Grb BAout Yin`. `ir_op` is decoded and latched.
  - If `ir_op` is not a supported opcode: pulse `illegal`, assert no strobes, go to IDLE, do not pulse `done`.
- T4: `Cout Zin`, `alu_op=ALU_ADD`.
- T5:
  - ldi: `Zlowout Gra Rin`, then DONE.
  - ld/st: `Zlowout MARin`.
- T6:
  - ld: memory step. `Read` is high for MEM_WAIT+1 cycles; `MDRin` is high in the final cycle.
  - st: `Gra Rout MDRin`, with `Read=0` so MDR loads from the bus.
- T7:
  - ld: `MDRout Gra Rin`.
  - st: `Write` is high for MEM_WAIT+1 cycles.
  - Either opcode then goes to DONE.
- DONE: `done=1`, `busy=0`, then IDLE. `start` in DONE is ignored; the next instruction is accepted from IDLE.
- Wait counter: $clog2(MEM_WAIT+1) bits wide (minimum 1). It loads 0 on entering a memory step, increments each cycle, and the step ends at count==MEM_WAIT. The counter is cleared on leaving the step.
- `start` while `busy` is ignored, with no queuing.

## Timing
- Reset: on `clear`, asynchronously force IDLE and counter 0. Every output is 0, including `alu_op=0` (never Z), `busy=0`, `done=0` and `illegal=0`.
- `clear` mid-operation aborts immediately. No strobe may be high in the cycle after `clear` is asserted. Operation resumes only on a new `start` after `clear` is deasserted.
- One state per clock unless stalled in a memory step.
- `busy` is high in the cycle after `start` is sampled.
- Cycle counts, `start` sample edge to `done` pulse, with W=MEM_WAIT:
  - ldi: 7+W cycles.
  - ld: 9+2W cycles.
  - st: 9+2W cycles.
- `illegal` pulses during the T3 cycle; the sequencer is back in IDLE on the next edge.
- No strobe glitches. Outputs change only after a rising edge of `clock` or on `clear`.

## Configuration
- `MEM_CTRL_SEQ_STORE_EN` defined: the st path (T6 `Gra Rout MDRin`, T7 `Write`) is compiled in.
- `MEM_CTRL_SEQ_STORE_EN` not defined:
  - `OP_ST` decodes as illegal.
  - `Write` and `Rout` are tied 0.
  - The st states and logic are absent.

## Test plan
- Reset: assert `clear` mid-T4 of an ld. Required next cycle: all outputs 0, `alu_op=5'b00000`. Then `start` runs a full fetch from T0.
- ld, MEM_WAIT=0, `ir_op=5'b00000`: exact strobe sequence T0–T7 as above, `alu_op=5'b00011` only in T4, `done` pulse 9 cycles after `start`, `busy` high for 8 cycles.
- ld, MEM_WAIT=3: `Read` high 4 cycles in T1 and 4 cycles in T6, `MDRin` only in the last cycle of each, `done` at cycle 15.
- ldi, `ir_op=5'b00001`: T5 shows `Zlowout Gra Rin`, no T6/T7, `done` at cycle 7.
- st with the macro defined, MEM_WAIT=1: T6 shows `Gra Rout MDRin` with `Read=0`, `Write` high 2 cycles, `done` at cycle 11.
- st with the macro undefined, and `ir_op=5'b11111` in both builds: `illegal` pulse in T3, no `Rin`/`Write`, no `done`, `busy` low next cycle. A `start` pulse during `busy` is ignored.
